init_param: RTL and testbench

//  Parametrised S-array initialiser for the ARC4 datapath; next generation of the fixed 256x8 init.
//  On an en/rdy handshake it streams one write per cycle into a single-port memory.

---
 rtl/init_param.sv | 127 ++++++++++++
 tb/tb_init_param.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/init_param.sv
// Parametrised S-array initialiser: on an accepted start it streams BEATS write beats
// (identity, constant or descending data, LANES entries per beat) into a single-port memory.
module init_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int LANES  = 1,
  // Derived beat-address width; leave at its default.
  parameter int ADDR_W = $clog2(DEPTH / LANES)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic [1:0]                mode,
  input  logic [DATA_W-1:0]         fill,
  input  logic                      abort,
  output logic                      rdy,
  output logic [ADDR_W-1:0]         addr,
  output logic [DATA_W*LANES-1:0]   wrdata,
  output logic                      wren,
  output logic                      done
);

  localparam int BEATS = DEPTH / LANES;
  // One spare bit so DEPTH-1-i and beat*LANES+k never overflow at the last beat.
  localparam int IDX_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST_BEAT = ADDR_W'(BEATS - 1);

  typedef enum logic {IDLE, FILL} state_e;

  state_e                    state_q, state_d;
  logic [ADDR_W-1:0]         addr_q, addr_d;
  logic [DATA_W*LANES-1:0]   wrdata_q, wrdata_d;
  logic                      wren_q, wren_d;
  logic                      done_q, done_d;
  logic [1:0]                mode_q, mode_d;
  logic [DATA_W-1:0]         fill_q, fill_d;
  logic [ADDR_W-1:0]         next_beat;

  function automatic logic [DATA_W*LANES-1:0] beat_data(input logic [ADDR_W-1:0] beat,
                                                        input logic [1:0]        m,
                                                        input logic [DATA_W-1:0] f);
    logic [IDX_W-1:0] idx;
    beat_data = '0;
    for (int k = 0; k < LANES; k++) begin
      idx = IDX_W'(beat) * IDX_W'(LANES) + IDX_W'(k);
      case (m)
        2'd1:    beat_data[k*DATA_W +: DATA_W] = f;
        2'd2:    beat_data[k*DATA_W +: DATA_W] = DATA_W'(IDX_W'(DEPTH - 1) - idx);
        default: beat_data[k*DATA_W +: DATA_W] = DATA_W'(idx);
      endcase
    end
  endfunction

  assign next_beat = addr_q + ADDR_W'(1);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, otherwise unassigned paths infer latches.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = FILL;
      FILL:    if (abort || addr_q == LAST_BEAT) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Final-beat check comes before abort so an abort on the last beat still pulses done.
  always_comb begin
    addr_d   = addr_q;
    wrdata_d = wrdata_q;
    wren_d   = 1'b0;
    done_d   = 1'b0;
    mode_d   = mode_q;
    fill_d   = fill_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          mode_d   = mode;
          fill_d   = fill;
          addr_d   = '0;
          wrdata_d = beat_data('0, mode, fill);
          wren_d   = 1'b1;
        end
      end
      FILL: begin
        if (addr_q == LAST_BEAT) begin
          done_d = 1'b1;
        end else if (!abort) begin
          addr_d   = next_beat;
          wrdata_d = beat_data(next_beat, mode_q, fill_q);
          wren_d   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q   <= '0;
      wrdata_q <= '0;
      wren_q   <= 1'b0;
      done_q   <= 1'b0;
      mode_q   <= 2'd0;
      fill_q   <= '0;
    end else begin
      addr_q   <= addr_d;
      wrdata_q <= wrdata_d;
      wren_q   <= wren_d;
      done_q   <= done_d;
      mode_q   <= mode_d;
      fill_q   <= fill_d;
    end
  end

  assign rdy    = (state_q == IDLE);
  assign addr   = addr_q;
  assign wrdata = wrdata_q;
  assign wren   = wren_q;
  assign done   = done_q;

endmodule

// File: tb/tb_init_param.sv
// Bench for init_param: three configurations (defaults, LANES=4, DEPTH=512) share one stimulus
// stream and are compared every cycle against a transaction-level model, plus literal pins.
module tb_init_param;

  localparam int N = 3;
  localparam int LANES_T [N] = '{1, 4, 1};
  localparam int DEPTH_T [N] = '{256, 256, 512};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] fill = 8'd0;

  logic        rdy0, wren0, done0;
  logic [7:0]  addr0;
  logic [7:0]  wd0;
  logic        rdy1, wren1, done1;
  logic [5:0]  addr1;
  logic [31:0] wd1;
  logic        rdy2, wren2, done2;
  logic [8:0]  addr2;
  logic [7:0]  wd2;

  init_param u_dut_def (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .fill(fill), .abort(abort),
    .rdy(rdy0), .addr(addr0), .wrdata(wd0), .wren(wren0), .done(done0)
  );

  init_param #(.LANES(4)) u_dut_l4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .fill(fill), .abort(abort),
    .rdy(rdy1), .addr(addr1), .wrdata(wd1), .wren(wren1), .done(done1)
  );

  init_param #(.DEPTH(512)) u_dut_d512 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .fill(fill), .abort(abort),
    .rdy(rdy2), .addr(addr2), .wrdata(wd2), .wren(wren2), .done(done2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  // Model: a fill is "beat n of BEATS in flight"; outputs follow from that and the latched request.
  bit          m_busy [N];
  int          m_beat [N];
  int          m_mode [N];
  int          m_fill [N];
  bit          e_rdy  [N];
  bit          e_wren [N];
  bit          e_done [N];
  int          e_addr [N];
  logic [31:0] e_data [N];

  // Write logs captured from the DUTs for the literal pins.
  logic [7:0]  mem0 [256];
  logic [31:0] mem1 [64];
  logic [7:0]  mem2 [512];
  int wc [N];
  int dc [N];
  int rl0;

  function automatic logic [31:0] beat_value(int inst, int beat, int m, int f);
    logic [31:0] r;
    int idx, v;
    r = '0;
    for (int k = 0; k < LANES_T[inst]; k++) begin
      idx = beat * LANES_T[inst] + k;
      if (m == 1)      v = f;
      else if (m == 2) v = DEPTH_T[inst] - 1 - idx;
      else             v = idx;
      r[k*8 +: 8] = 8'(v);
    end
    return r;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      e_done[i] = 1'b0;
      if (rst) begin
        m_busy[i] = 1'b0;
        e_wren[i] = 1'b0;
        e_addr[i] = 0;
        e_data[i] = '0;
      end else if (!m_busy[i]) begin
        e_wren[i] = 1'b0;
        if (en) begin
          m_busy[i] = 1'b1;
          m_beat[i] = 0;
          m_mode[i] = int'(mode);
          m_fill[i] = int'(fill);
        end
      end else if (m_beat[i] == DEPTH_T[i] / LANES_T[i] - 1) begin
        m_busy[i] = 1'b0;
        e_done[i] = 1'b1;
        e_wren[i] = 1'b0;
      end else if (abort) begin
        m_busy[i] = 1'b0;
        e_wren[i] = 1'b0;
      end else begin
        m_beat[i] = m_beat[i] + 1;
      end
      if (m_busy[i]) begin
        e_wren[i] = 1'b1;
        e_addr[i] = m_beat[i];
        e_data[i] = beat_value(i, m_beat[i], m_mode[i], m_fill[i]);
      end
      e_rdy[i] = !m_busy[i];
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Advance one cycle, sample at the falling edge, compare every DUT against the model, log writes.
  task automatic tick();
    logic        a_rdy [N];
    logic        a_wren [N];
    logic        a_done [N];
    logic [31:0] a_addr [N];
    logic [31:0] a_data [N];
    @(negedge clk);
    a_rdy[0] = rdy0; a_wren[0] = wren0; a_done[0] = done0; a_addr[0] = 32'(addr0); a_data[0] = 32'(wd0);
    a_rdy[1] = rdy1; a_wren[1] = wren1; a_done[1] = done1; a_addr[1] = 32'(addr1); a_data[1] = wd1;
    a_rdy[2] = rdy2; a_wren[2] = wren2; a_done[2] = done2; a_addr[2] = 32'(addr2); a_data[2] = 32'(wd2);
    if (chk_on) begin
      for (int i = 0; i < N; i++) begin
        checks++;
        if (a_rdy[i] !== e_rdy[i] || a_wren[i] !== e_wren[i] || a_done[i] !== e_done[i] ||
            a_addr[i] !== 32'(e_addr[i]) || a_data[i] !== e_data[i]) begin
          errors++;
          $display("FAIL model_cmp dut%0d at %0t: got rdy=%b wren=%b done=%b addr=%0d data=%h expected rdy=%b wren=%b done=%b addr=%0d data=%h",
                   i, $time, a_rdy[i], a_wren[i], a_done[i], a_addr[i], a_data[i],
                   e_rdy[i], e_wren[i], e_done[i], e_addr[i], e_data[i]);
        end
      end
    end
    if (wren0 === 1'b1) begin mem0[addr0] = wd0; wc[0]++; end
    if (wren1 === 1'b1) begin mem1[addr1] = wd1; wc[1]++; end
    if (wren2 === 1'b1) begin mem2[addr2] = wd2; wc[2]++; end
    if (done0 === 1'b1) dc[0]++;
    if (done1 === 1'b1) dc[1]++;
    if (done2 === 1'b1) dc[2]++;
    if (rdy0 === 1'b0) rl0++;
  endtask

  task automatic clear_logs();
    for (int i = 0; i < N; i++) begin
      wc[i] = 0;
      dc[i] = 0;
    end
    rl0 = 0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (!(rdy0 === 1'b1 && rdy1 === 1'b1 && rdy2 === 1'b1) && n < budget) begin
      tick();
      n++;
    end
    if (!(rdy0 === 1'b1 && rdy1 === 1'b1 && rdy2 === 1'b1)) begin
      checks++;
      errors++;
      $display("FAIL wait_idle: rdy=%b%b%b after %0d cycles, required 111", rdy0, rdy1, rdy2, budget);
    end
  endtask

  task automatic wait_addr0(input int target, input int budget);
    int n;
    n = 0;
    while (!(wren0 === 1'b1 && int'(addr0) == target) && n < budget) begin
      tick();
      n++;
    end
    if (!(wren0 === 1'b1 && int'(addr0) == target)) begin
      checks++;
      errors++;
      $display("FAIL wait_addr: addr=%0d wren=%b, required addr %0d with wren=1", addr0, wren0, target);
    end
  endtask

  initial begin
    int bad;
    int n;
    int wc_before;

    rst = 1'b1;
    repeat (2) tick();
    chk_on = 1'b1;
    check("reset_def", 32'({rdy0, wren0, done0, addr0, wd0}), 32'({1'b1, 1'b0, 1'b0, 8'h00, 8'h00}));
    check("reset_l4_rdy", 32'(rdy1), 32'd1);
    rst = 1'b0;
    tick();

    // Identity fill on all three configurations.
    clear_logs();
    mode = 2'd0;
    en = 1'b1;
    tick();
    en = 1'b0;
    wait_idle(700);
    check("t1_writes", wc[0], 256);
    check("t1_rdy_low", rl0, 256);
    check("t1_done_pulses", dc[0], 1);
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem0[k] !== 8'(k)) bad++;
    check("t1_identity_bad", bad, 0);
    check("t2_l4_writes", wc[1], 64);
    check("t2_l4_beat1", mem1[1], 32'h07060504);
    check("t2_l4_beat63", mem1[63], 32'hFFFEFDFC);
    check("t2_l4_done", dc[1], 1);
    check("t6_d512_writes", wc[2], 512);
    check("t6_d512_addr300", 32'(mem2[300]), 32'd44);
    check("t6_d512_addr511", 32'(mem2[511]), 32'd255);

    // Descending, then constant with mode/fill disturbed after acceptance.
    clear_logs();
    mode = 2'd2;
    en = 1'b1;
    tick();
    en = 1'b0;
    mode = 2'd0;
    wait_idle(700);
    check("t3_desc_addr0", 32'(mem0[0]), 32'd255);
    check("t3_desc_addr255", 32'(mem0[255]), 32'd0);
    check("t3_desc_addr100", 32'(mem0[100]), 32'd155);
    clear_logs();
    mode = 2'd1;
    fill = 8'hA5;
    en = 1'b1;
    tick();
    en = 1'b0;
    fill = 8'h3C;
    mode = 2'd2;
    wait_idle(700);
    bad = 0;
    for (int k = 0; k < 256; k++) if (mem0[k] !== 8'hA5) bad++;
    check("t3_const_bad", bad, 0);
    check("t3_const_writes", wc[0], 256);
    check("t3_const_l4", mem1[10], 32'hA5A5A5A5);

    // Abort while beat 100 is on the port.
    clear_logs();
    mode = 2'd0;
    en = 1'b1;
    tick();
    en = 1'b0;
    wait_addr0(100, 300);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_after_abort", 32'({rdy0, wren0, done0}), 32'({1'b1, 1'b0, 1'b0}));
    wait_idle(700);
    repeat (3) tick();
    check("t4_writes", wc[0], 101);
    check("t4_no_done", dc[0], 0);
    check("t4_d512_writes", wc[2], 101);
    check("t4_l4_done", dc[1], 1);
    en = 1'b1;
    tick();
    en = 1'b0;
    check("t4_restart", 32'({wren0, addr0}), 32'({1'b1, 8'd0}));

    // Synchronous reset mid-fill.
    wait_addr0(50, 100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_reset_def", 32'({rdy0, wren0, done0, addr0, wd0}), 32'({1'b1, 1'b0, 1'b0, 8'h00, 8'h00}));
    check("t5_reset_d512", 32'({rdy2, wren2, done2, addr2}), 32'({1'b1, 1'b0, 1'b0, 9'd0}));

    // en held through a fill and into the done cycle: one back-to-back restart only there.
    clear_logs();
    mode = 2'd0;
    en = 1'b1;
    tick();
    n = 0;
    while (done0 !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    check("t5_done_seen", 32'(done0), 32'd1);
    wc_before = wc[0];
    tick();
    en = 1'b0;
    check("t5_first_fill_writes", wc_before, 256);
    check("t5_back_to_back", 32'({wren0, rdy0, addr0}), 32'({1'b1, 1'b0, 8'd0}));
    wait_idle(1200);

    // Randomised traffic against the model.
    repeat (4000) begin
      en    = ($urandom_range(0, 3) == 0);
      mode  = 2'($urandom);
      fill  = 8'($urandom);
      abort = ($urandom_range(0, 63) == 0);
      rst   = ($urandom_range(0, 999) == 0);
      tick();
    end
    rst = 1'b0;
    en = 1'b0;
    abort = 1'b0;
    wait_idle(700);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
